// File: rtl/set_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : set_cmd_dispatcher
// Brief    : Buffers circle-query commands in a FIFO, launches them into SET
//            one at a time and holds each result on a ready/valid port.
//            Optional run watchdog enabled by defining SET_DISP_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module set_cmd_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_central,
    input  logic [11:0] cmd_radius,
    input  logic [1:0]  cmd_mode,
    output logic        set_en,
    output logic [23:0] set_central,
    output logic [11:0] set_radius,
    output logic [1:0]  set_mode,
    input  logic        set_busy,
    input  logic        set_valid,
    input  logic [7:0]  set_candidate,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_candidate,
    output logic        res_err
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_ENTRY_W = 38;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_LAUNCH = 2'd1;
    localparam logic [1:0] c_ST_RUN    = 2'd2;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 1)) begin : g_param_check
        $error("set_cmd_dispatcher: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    logic [c_ENTRY_W-1:0] r_fifo_q [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0]   r_rd_ptr_q, w_rd_ptr_d;
    logic [c_CNT_W-1:0]   r_count_q,  w_count_d;

    logic [1:0]  r_state_q,         w_state_d;
    logic        r_set_en_q,        w_set_en_d;
    logic [23:0] r_set_central_q,   w_set_central_d;
    logic [11:0] r_set_radius_q,    w_set_radius_d;
    logic [1:0]  r_set_mode_q,      w_set_mode_d;
    logic        r_res_valid_q,     w_res_valid_d;
    logic [7:0]  r_res_candidate_q, w_res_candidate_d;

    logic                 w_push;
    logic                 w_launch;
    logic [c_ENTRY_W-1:0] w_head;

`ifdef SET_DISP_TIMEOUT_EN
    localparam int c_TMR_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [c_TMR_W-1:0] c_TMO_LIMIT = c_TMR_W'(TIMEOUT);

    logic               r_res_err_q, w_res_err_d;
    logic [c_TMR_W-1:0] r_timer_q,   w_timer_d;

    assign res_err = r_res_err_q;
`else
    assign res_err = 1'b0;
`endif

    assign cmd_ready = (r_count_q != c_CNT_W'(DEPTH));
    assign w_push    = cmd_valid && cmd_ready;
    assign w_head    = r_fifo_q[r_rd_ptr_q];

    // Launch only from registered FIFO state, so a command pushed this cycle waits a cycle.
    assign w_launch  = (r_state_q == c_ST_IDLE) && (r_count_q != '0) &&
                       !set_busy && !r_res_valid_q;

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_push) begin
            w_wr_ptr_d = r_wr_ptr_q + c_PTR_W'(1);
        end
        if (w_launch) begin
            w_rd_ptr_d = r_rd_ptr_q + c_PTR_W'(1);
        end
        if (w_push && !w_launch) begin
            w_count_d = r_count_q + c_CNT_W'(1);
        end else if (!w_push && w_launch) begin
            w_count_d = r_count_q - c_CNT_W'(1);
        end
    end

    always_comb begin
        w_state_d         = r_state_q;
        w_set_en_d        = 1'b0;
        w_set_central_d   = r_set_central_q;
        w_set_radius_d    = r_set_radius_q;
        w_set_mode_d      = r_set_mode_q;
        w_res_valid_d     = r_res_valid_q;
        w_res_candidate_d = r_res_candidate_q;
`ifdef SET_DISP_TIMEOUT_EN
        w_res_err_d       = r_res_err_q;
        w_timer_d         = r_timer_q;
`endif
        if (r_res_valid_q && res_ready) begin
            w_res_valid_d = 1'b0;
        end

        case (r_state_q)
            c_ST_IDLE: begin
                if (w_launch) begin
                    w_set_central_d = w_head[37:14];
                    w_set_radius_d  = w_head[13:2];
                    w_set_mode_d    = w_head[1:0];
                    w_set_en_d      = 1'b1;
                    w_state_d       = c_ST_LAUNCH;
                end
            end
            c_ST_LAUNCH: begin
`ifdef SET_DISP_TIMEOUT_EN
                w_timer_d = '0;
`endif
                w_state_d = c_ST_RUN;
            end
            c_ST_RUN: begin
                // Command fields stay frozen here: SET reads mode combinationally all run.
                if (set_valid) begin
                    w_res_candidate_d = set_candidate;
                    w_res_valid_d     = 1'b1;
`ifdef SET_DISP_TIMEOUT_EN
                    w_res_err_d       = 1'b0;
`endif
                    w_state_d         = c_ST_IDLE;
                end
`ifdef SET_DISP_TIMEOUT_EN
                else if (r_timer_q == c_TMO_LIMIT) begin
                    w_res_candidate_d = 8'hFF;
                    w_res_err_d       = 1'b1;
                    w_res_valid_d     = 1'b1;
                    w_state_d         = c_ST_IDLE;
                end else begin
                    w_timer_d = r_timer_q + c_TMR_W'(1);
                end
`endif
            end
            default: begin
                w_state_d = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_q[r_wr_ptr_q] <= {cmd_central, cmd_radius, cmd_mode};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q        <= '0;
            r_rd_ptr_q        <= '0;
            r_count_q         <= '0;
            r_state_q         <= c_ST_IDLE;
            r_set_en_q        <= 1'b0;
            r_set_central_q   <= '0;
            r_set_radius_q    <= '0;
            r_set_mode_q      <= '0;
            r_res_valid_q     <= 1'b0;
            r_res_candidate_q <= '0;
`ifdef SET_DISP_TIMEOUT_EN
            r_res_err_q       <= 1'b0;
            r_timer_q         <= '0;
`endif
        end else begin
            r_wr_ptr_q        <= w_wr_ptr_d;
            r_rd_ptr_q        <= w_rd_ptr_d;
            r_count_q         <= w_count_d;
            r_state_q         <= w_state_d;
            r_set_en_q        <= w_set_en_d;
            r_set_central_q   <= w_set_central_d;
            r_set_radius_q    <= w_set_radius_d;
            r_set_mode_q      <= w_set_mode_d;
            r_res_valid_q     <= w_res_valid_d;
            r_res_candidate_q <= w_res_candidate_d;
`ifdef SET_DISP_TIMEOUT_EN
            r_res_err_q       <= w_res_err_d;
            r_timer_q         <= w_timer_d;
`endif
        end
    end

    assign set_en        = r_set_en_q;
    assign set_central   = r_set_central_q;
    assign set_radius    = r_set_radius_q;
    assign set_mode      = r_set_mode_q;
    assign res_valid     = r_res_valid_q;
    assign res_candidate = r_res_candidate_q;

endmodule
`default_nettype wire

// File: tb/tb_set_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_set_cmd_dispatcher
// Brief    : Directed bench for set_cmd_dispatcher with a behavioural SET stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_set_cmd_dispatcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_central;
    logic [11:0] cmd_radius;
    logic [1:0]  cmd_mode;
    logic        set_en;
    logic [23:0] set_central;
    logic [11:0] set_radius;
    logic [1:0]  set_mode;
    logic        set_busy;
    logic        set_valid;
    logic [7:0]  set_candidate;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_candidate;
    logic        res_err;

    always #5 clk = ~clk;

    set_cmd_dispatcher #(.DEPTH(4), .TIMEOUT(20)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_central(cmd_central), .cmd_radius(cmd_radius), .cmd_mode(cmd_mode),
        .set_en(set_en), .set_central(set_central), .set_radius(set_radius),
        .set_mode(set_mode), .set_busy(set_busy), .set_valid(set_valid),
        .set_candidate(set_candidate), .res_valid(res_valid), .res_ready(res_ready),
        .res_candidate(res_candidate), .res_err(res_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural SET: 8x8 grid, points 0..7 in x and y.
    function automatic logic [7:0] set_count(input logic [23:0] c, input logic [11:0] r,
                                             input logic [1:0] m);
        int  n = 0;
        int  ax, ay, bx, by, ra, rb;
        logic ina, inb, hit;
        ax = int'(c[23:20]); ay = int'(c[19:16]);
        bx = int'(c[15:12]); by = int'(c[11:8]);
        ra = int'(r[11:8]);  rb = int'(r[7:4]);
        for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
                ina = ((x - ax) * (x - ax) + (y - ay) * (y - ay)) <= ra * ra;
                inb = ((x - bx) * (x - bx) + (y - by) * (y - by)) <= rb * rb;
                case (m)
                    2'd0:    hit = ina;
                    2'd1:    hit = ina && inb;
                    2'd2:    hit = ina ^ inb;
                    default: hit = 1'b0;
                endcase
                if (hit) n++;
            end
        end
        return n[7:0];
    endfunction

    logic       m_busy;
    int         m_cnt;
    logic [7:0] m_cand;
    logic [1:0] m_mode;
    logic       mute = 1'b0;
    logic       spur = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_cand <= '0;
            m_mode <= '0;
        end else if (set_en) begin
            m_busy <= 1'b1;
            m_cnt  <= 1;
            m_cand <= set_count(set_central, set_radius, set_mode);
            m_mode <= set_mode;
        end else if (m_busy) begin
            if (m_cnt >= 66) m_busy <= 1'b0;
            m_cnt <= m_cnt + 1;
        end
    end

    assign set_busy      = m_busy;
    assign set_valid     = (m_busy && (m_cnt == 65) && !mute) || spur;
    assign set_candidate = spur ? 8'd7 : m_cand;

    int         cyc = 0;
    int         en_cnt = 0, en_wide = 0, en_cyc = 0, lat = 0, mode_bad = 0, hold_bad = 0;
    logic       p_en = 1'b0, p_rv = 1'b0, p_rr = 1'b0, p_err = 1'b0;
    logic [7:0] p_cand = '0;
    logic [7:0] q_cand[$];
    logic       q_err[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            p_en = 1'b0;
            p_rv = 1'b0;
            p_rr = 1'b0;
        end else begin
            if (set_en) begin
                en_cnt++;
                en_cyc = cyc;
                if (p_en) en_wide++;
            end
            if (res_valid && !p_rv) lat = cyc - en_cyc;
            if (p_rv && !p_rr && (!res_valid || res_candidate != p_cand || res_err != p_err))
                hold_bad++;
            if (m_busy && set_mode != m_mode) mode_bad++;
            if (res_valid && res_ready) begin
                q_cand.push_back(res_candidate);
                q_err.push_back(res_err);
            end
            p_en = set_en; p_rv = res_valid; p_rr = res_ready;
            p_cand = res_candidate; p_err = res_err;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
        int n = 0;
        cmd_valid = 1'b1; cmd_central = c; cmd_radius = r; cmd_mode = m;
        @(negedge clk);
        while (!cmd_ready && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (n >= 500) check("push_timeout", 64'(n), 64'(0));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int k = 0;
        while (q_cand.size() < n && k < 3000) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (q_cand.size() < n) check("result_timeout", 64'(q_cand.size()), 64'(n));
    endtask

    task automatic expect_res(input string tag, input logic [7:0] cand, input logic err);
        if (q_cand.size() == 0) begin
            check({tag, "_missing"}, 64'(0), 64'(1));
        end else begin
            check(tag, 64'(q_cand.pop_front()), 64'(cand));
            check({tag, "_err"}, 64'(q_err.pop_front()), 64'(err));
        end
    endtask

    initial begin
        int snap;
        int k;
        rst = 1'b1; cmd_valid = 1'b0; cmd_central = '0; cmd_radius = '0; cmd_mode = '0;
        res_ready = 1'b1;

        tick(1);
        check("rst_outputs", 64'({set_en, res_valid, res_err, set_central, set_radius,
                                  set_mode, res_candidate}), 64'(0));
        tick(1);
        rst = 1'b0;
        tick(1);
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("post_rst_no_set_en", 64'(en_cnt), 64'(0));

        // Single command, circle radius 2 at (4,4)
        push(24'h440000, 12'h200, 2'd0);
        wait_results(1);
        expect_res("single", 8'd13, 1'b0);
        check("single_latency", 64'(lat), 64'(66));
        check("single_en_count", 64'(en_cnt), 64'(1));

        // Modes with A == B
        push(24'h444400, 12'h220, 2'd1);
        push(24'h444400, 12'h220, 2'd2);
        push(24'h444400, 12'h220, 2'd3);
        wait_results(3);
        expect_res("mode_and", 8'd13, 1'b0);
        expect_res("mode_xor", 8'd0, 1'b0);
        expect_res("mode_rsvd", 8'd0, 1'b0);
        check("modes_en_count", 64'(en_cnt), 64'(4));
        tick(5);

        // Backpressure: five back-to-back pushes with consumer stalled
        res_ready = 1'b0;
        push(24'h440000, 12'h000, 2'd0);
        push(24'h440000, 12'h100, 2'd0);
        push(24'h000000, 12'h200, 2'd0);
        push(24'h440000, 12'h300, 2'd0);
        push(24'h440000, 12'h200, 2'd0);
        check("full_cmd_ready", 64'(cmd_ready), 64'(0));
        k = 0;
        while (!res_valid && k < 200) begin
            tick(1);
            k++;
        end
        check("bp_first_result", 64'(res_valid), 64'(1));
        snap = en_cnt;
        tick(100);
        check("hold_res_valid", 64'(res_valid), 64'(1));
        check("hold_no_launch", 64'(en_cnt), 64'(snap));
        check("hold_cmd_ready", 64'(cmd_ready), 64'(0));
        check("hold_stable", 64'(hold_bad), 64'(0));
        res_ready = 1'b1;
        wait_results(5);
        expect_res("bp_r0", 8'd1, 1'b0);
        expect_res("bp_r1", 8'd5, 1'b0);
        expect_res("bp_corner", 8'd6, 1'b0);
        expect_res("bp_r3", 8'd29, 1'b0);
        expect_res("bp_r2", 8'd13, 1'b0);
        check("bp_en_count", 64'(en_cnt), 64'(9));
        check("set_en_width", 64'(en_wide), 64'(0));
        check("mode_stable", 64'(mode_bad), 64'(0));

        // Stray strobe while idle
        tick(5);
        spur = 1'b1;
        tick(1);
        spur = 1'b0;
        tick(3);
        check("spurious_valid_ignored", 64'(res_valid), 64'(0));
        check("spurious_no_result", 64'(q_cand.size()), 64'(0));

        // SET never answers
        mute = 1'b1;
        push(24'h440000, 12'h200, 2'd0);
`ifdef SET_DISP_TIMEOUT_EN
        wait_results(1);
        expect_res("timeout", 8'hFF, 1'b1);
        check("timeout_latency", 64'(lat), 64'(22));
`else
        tick(300);
        check("no_timeout_res_valid", 64'(res_valid), 64'(0));
        check("no_timeout_res_err", 64'(res_err), 64'(0));
        check("no_timeout_en_count", 64'(en_cnt), 64'(10));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
